// File: rtl/fighter_action_ctrl.sv
// rtl/fighter_action_ctrl.sv - two-player frame-timed action sequencer (walk/attack/block phases)
// Optional macro ATTACK_BUFFER_EN: an attack pressed during RECOVER chains straight into WINDUP.

module fighter_action_player #(
  parameter int WINDUP_FRAMES  = 3,
  parameter int ACTIVE_FRAMES  = 2,
  parameter int RECOVER_FRAMES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       l,
  input  logic       r,
  input  logic       atk,
  input  logic       def,
  output logic [2:0] state,
  output logic [1:0] dir,
  output logic       strike,
  output logic       blocking
);
  localparam int MAX_WA     = (WINDUP_FRAMES > ACTIVE_FRAMES) ? WINDUP_FRAMES : ACTIVE_FRAMES;
  localparam int MAX_FRAMES = (MAX_WA > RECOVER_FRAMES) ? MAX_WA : RECOVER_FRAMES;
  localparam int CW         = $clog2(MAX_FRAMES) + 1;
  localparam logic [CW-1:0] WINDUP_LOAD  = CW'(WINDUP_FRAMES - 1);
  localparam logic [CW-1:0] ACTIVE_LOAD  = CW'(ACTIVE_FRAMES - 1);
  localparam logic [CW-1:0] RECOVER_LOAD = CW'(RECOVER_FRAMES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WALK    = 3'd1,
    WINDUP  = 3'd2,
    ACTIVE  = 3'd3,
    RECOVER = 3'd4,
    BLOCK   = 3'd5
  } phase_t;

  phase_t        cur, nxt;
  logic [1:0]    dir_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          atk_prev;
  logic          atk_edge;
`ifdef ATTACK_BUFFER_EN
  logic          atk_buf, atk_buf_nxt;
`endif

  assign atk_edge = atk & ~atk_prev;
  assign state    = cur;
  assign blocking = (cur == BLOCK);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cur      <= IDLE;
      dir      <= 2'b00;
      cnt      <= '0;
      atk_prev <= 1'b0;
      strike   <= 1'b0;
`ifdef ATTACK_BUFFER_EN
      atk_buf  <= 1'b0;
`endif
    end else begin
      // strike lives for exactly one Clk, independent of tick spacing
      strike <= frame_tick && (cur == WINDUP) && (cnt == '0);
      if (frame_tick) begin
        cur      <= nxt;
        dir      <= dir_nxt;
        cnt      <= cnt_nxt;
        atk_prev <= atk;
`ifdef ATTACK_BUFFER_EN
        atk_buf  <= atk_buf_nxt;
`endif
      end
    end
  end

  always_comb begin
    nxt     = cur;
    dir_nxt = dir;
    cnt_nxt = cnt;
`ifdef ATTACK_BUFFER_EN
    atk_buf_nxt = atk_buf;
`endif
    case (cur)
      WINDUP, ACTIVE, RECOVER: begin
        dir_nxt = 2'b00;
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (cur == WINDUP) begin
          nxt     = ACTIVE;
          cnt_nxt = ACTIVE_LOAD;
        end else if (cur == ACTIVE) begin
          nxt     = RECOVER;
          cnt_nxt = RECOVER_LOAD;
        end else begin
          nxt = IDLE;
        end
`ifdef ATTACK_BUFFER_EN
        // an edge on the final RECOVER tick still chains into the next attack
        if (cur == RECOVER) begin
          if (atk_edge) atk_buf_nxt = 1'b1;
          if ((cnt == '0) && (atk_buf || atk_edge)) begin
            nxt         = WINDUP;
            cnt_nxt     = WINDUP_LOAD;
            atk_buf_nxt = 1'b0;
          end
        end
`endif
      end
      default: begin
        // IDLE, WALK and BLOCK share one priority: attack, defense, then movement
        if (atk_edge) begin
          nxt     = WINDUP;
          dir_nxt = 2'b00;
          cnt_nxt = WINDUP_LOAD;
        end else if (def) begin
          nxt     = BLOCK;
          dir_nxt = 2'b00;
        end else if (l ^ r) begin
          nxt     = WALK;
          dir_nxt = {r, l};
        end else begin
          nxt     = IDLE;
          dir_nxt = 2'b00;
        end
      end
    endcase
  end
endmodule

module fighter_action_ctrl #(
  parameter int WINDUP_FRAMES  = 3,
  parameter int ACTIVE_FRAMES  = 2,
  parameter int RECOVER_FRAMES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       p1_l,
  input  logic       p1_r,
  input  logic       p1_atk,
  input  logic       p1_def,
  input  logic       p2_l,
  input  logic       p2_r,
  input  logic       p2_atk,
  input  logic       p2_def,
  output logic [2:0] p1_state,
  output logic [2:0] p2_state,
  output logic [1:0] p1_dir,
  output logic [1:0] p2_dir,
  output logic       p1_strike,
  output logic       p2_strike,
  output logic       p1_blocking,
  output logic       p2_blocking
);
  fighter_action_player #(
    .WINDUP_FRAMES (WINDUP_FRAMES),
    .ACTIVE_FRAMES (ACTIVE_FRAMES),
    .RECOVER_FRAMES(RECOVER_FRAMES)
  ) u_p1 (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_tick(frame_tick),
    .l         (p1_l),
    .r         (p1_r),
    .atk       (p1_atk),
    .def       (p1_def),
    .state     (p1_state),
    .dir       (p1_dir),
    .strike    (p1_strike),
    .blocking  (p1_blocking)
  );

  fighter_action_player #(
    .WINDUP_FRAMES (WINDUP_FRAMES),
    .ACTIVE_FRAMES (ACTIVE_FRAMES),
    .RECOVER_FRAMES(RECOVER_FRAMES)
  ) u_p2 (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_tick(frame_tick),
    .l         (p2_l),
    .r         (p2_r),
    .atk       (p2_atk),
    .def       (p2_def),
    .state     (p2_state),
    .dir       (p2_dir),
    .strike    (p2_strike),
    .blocking  (p2_blocking)
  );
endmodule

// File: tb/tb_fighter_action_ctrl.sv
// tb/tb_fighter_action_ctrl.sv - directed and randomized checks of fighter_action_ctrl
// Behaviour under ATTACK_BUFFER_EN follows the same macro.

module tb_fighter_action_ctrl;
  localparam int WF = 3, AF = 2, RF = 4;
  localparam int S_IDLE = 0, S_WALK = 1, S_WINDUP = 2, S_ACTIVE = 3, S_RECOVER = 4, S_BLOCK = 5;

  logic Clk = 1'b0, Reset = 1'b0, frame_tick = 1'b0;
  logic p1_l = 0, p1_r = 0, p1_atk = 0, p1_def = 0;
  logic p2_l = 0, p2_r = 0, p2_atk = 0, p2_def = 0;
  logic [2:0] p1_state, p2_state;
  logic [1:0] p1_dir, p2_dir;
  logic p1_strike, p2_strike, p1_blocking, p2_blocking;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: phase plus ticks already spent in it
  int m_phase[2], m_elapsed[2], m_dir[2];
  bit m_prev[2], m_strike[2], m_buf[2];

  fighter_action_ctrl #(.WINDUP_FRAMES(WF), .ACTIVE_FRAMES(AF), .RECOVER_FRAMES(RF)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .p1_l(p1_l), .p1_r(p1_r), .p1_atk(p1_atk), .p1_def(p1_def),
    .p2_l(p2_l), .p2_r(p2_r), .p2_atk(p2_atk), .p2_def(p2_def),
    .p1_state(p1_state), .p2_state(p2_state), .p1_dir(p1_dir), .p2_dir(p2_dir),
    .p1_strike(p1_strike), .p2_strike(p2_strike),
    .p1_blocking(p1_blocking), .p2_blocking(p2_blocking)
  );

  always #5 Clk = ~Clk;

  function automatic int phase_len(input int ph);
    return (ph == S_WINDUP) ? WF : (ph == S_ACTIVE) ? AF : RF;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_phase[p] = S_IDLE; m_elapsed[p] = 0; m_dir[p] = 0;
      m_prev[p] = 0; m_strike[p] = 0; m_buf[p] = 0;
    end
  endtask

  task automatic model_tick(input int p, input bit l, input bit r, input bit a, input bit d);
    bit edge_seen;
    edge_seen   = a && !m_prev[p];
    m_prev[p]   = a;
    m_strike[p] = 0;
    if (m_phase[p] == S_WINDUP || m_phase[p] == S_ACTIVE || m_phase[p] == S_RECOVER) begin
      m_dir[p] = 0;
`ifdef ATTACK_BUFFER_EN
      if (m_phase[p] == S_RECOVER && edge_seen) m_buf[p] = 1;
`endif
      if (m_elapsed[p] < phase_len(m_phase[p])) begin
        m_elapsed[p]++;
      end else begin
        m_elapsed[p] = 1;
        if (m_phase[p] == S_WINDUP) begin
          m_phase[p] = S_ACTIVE; m_strike[p] = 1;
        end else if (m_phase[p] == S_ACTIVE) begin
          m_phase[p] = S_RECOVER;
        end else if (m_buf[p]) begin
          m_phase[p] = S_WINDUP; m_buf[p] = 0;
        end else begin
          m_phase[p] = S_IDLE;
        end
      end
    end else if (edge_seen) begin
      m_phase[p] = S_WINDUP; m_elapsed[p] = 1; m_dir[p] = 0;
    end else if (d) begin
      m_phase[p] = S_BLOCK; m_dir[p] = 0;
    end else if (l != r) begin
      m_phase[p] = S_WALK; m_dir[p] = l ? 1 : 2;
    end else begin
      m_phase[p] = S_IDLE; m_dir[p] = 0;
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(posedge Clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic gap();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; frame_tick = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0; frame_tick = 1'b0;
    model_reset();
  endtask

  task automatic clear_keys();
    {p1_l, p1_r, p1_atk, p1_def, p2_l, p2_r, p2_atk, p2_def} = 8'h00;
  endtask

  task automatic rand_keys();
    {p1_l, p1_r, p1_atk, p1_def, p2_l, p2_r, p2_atk, p2_def} = 8'($urandom);
  endtask

  task automatic test_reset();
    rand_keys();
    do_reset();
    n_checks++;
    if ({p1_state, p1_dir, p1_strike, p1_blocking, p2_state, p2_dir, p2_strike, p2_blocking} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", {p1_state, p1_dir, p1_strike, p1_blocking, p2_state, p2_dir, p2_strike, p2_blocking});
    end
  endtask

  task automatic test_attack_hold();
    int strikes = 0;
    int exp_st;
    clear_keys(); do_reset();
    p1_atk = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      exp_st = (t <= 3) ? S_WINDUP : (t <= 5) ? S_ACTIVE : (t <= 9) ? S_RECOVER : S_IDLE;
      n_checks++;
      if (p1_state !== 3'(exp_st)) begin
        n_fail++; $display("FAIL hold_state tick=%0d got=%0d exp=%0d", t, p1_state, exp_st);
      end
      n_checks++;
      if (p1_strike !== (t == 4)) begin
        n_fail++; $display("FAIL hold_strike tick=%0d got=%b exp=%b", t, p1_strike, (t == 4));
      end
      strikes += int'(p1_strike);
      gap();
      n_checks++;
      if (p1_strike !== 1'b0 || p1_state !== 3'(exp_st)) begin
        n_fail++; $display("FAIL hold_between tick=%0d strike=%b state=%0d exp_state=%0d", t, p1_strike, p1_state, exp_st);
      end
    end
    n_checks++;
    if (strikes != 1) begin
      n_fail++; $display("FAIL hold_strike_count got=%0d exp=1", strikes);
    end
  endtask

  task automatic test_p2_atk_def();
    clear_keys(); do_reset();
    p2_atk = 1'b1; p2_def = 1'b1;
    tick();
    n_checks++;
    if (p2_state !== 3'(S_WINDUP) || p2_blocking !== 1'b0) begin
      n_fail++; $display("FAIL atkdef_first got_state=%0d blk=%b exp_state=2 blk=0", p2_state, p2_blocking);
    end
    p2_atk = 1'b0;
    for (int t = 2; t <= 9; t++) tick();
    n_checks++;
    if (p2_state !== 3'(S_RECOVER)) begin
      n_fail++; $display("FAIL atkdef_recover got=%0d exp=4", p2_state);
    end
    tick();
    n_checks++;
    if (p2_state !== 3'(S_IDLE)) begin
      n_fail++; $display("FAIL atkdef_idle got=%0d exp=0", p2_state);
    end
    tick();
    n_checks++;
    if (p2_state !== 3'(S_BLOCK) || p2_blocking !== 1'b1 || p2_dir !== 2'b00 || p1_state !== 3'(S_IDLE)) begin
      n_fail++; $display("FAIL atkdef_block got_state=%0d blk=%b dir=%b p1=%0d exp 5/1/00/0", p2_state, p2_blocking, p2_dir, p1_state);
    end
  endtask

  task automatic test_walk();
    clear_keys(); do_reset();
    p1_l = 1'b1; p1_r = 1'b1; tick();
    n_checks++;
    if ({p1_state, p1_dir} !== {3'd0, 2'b00}) begin
      n_fail++; $display("FAIL walk_both got=%0d/%b exp=0/00", p1_state, p1_dir);
    end
    p1_r = 1'b0; tick();
    n_checks++;
    if ({p1_state, p1_dir} !== {3'd1, 2'b01}) begin
      n_fail++; $display("FAIL walk_left got=%0d/%b exp=1/01", p1_state, p1_dir);
    end
    p1_l = 1'b0; p1_r = 1'b1; tick();
    n_checks++;
    if ({p1_state, p1_dir} !== {3'd1, 2'b10}) begin
      n_fail++; $display("FAIL walk_right got=%0d/%b exp=1/10", p1_state, p1_dir);
    end
    p1_r = 1'b0; p1_def = 1'b1; tick();
    n_checks++;
    if ({p1_state, p1_dir, p1_blocking} !== {3'd5, 2'b00, 1'b1}) begin
      n_fail++; $display("FAIL walk_block got=%0d/%b/%b exp=5/00/1", p1_state, p1_dir, p1_blocking);
    end
    p1_def = 1'b0; p1_l = 1'b1; tick();
    n_checks++;
    if ({p1_state, p1_dir, p1_blocking} !== {3'd1, 2'b01, 1'b0}) begin
      n_fail++; $display("FAIL walk_unblock got=%0d/%b/%b exp=1/01/0", p1_state, p1_dir, p1_blocking);
    end
  endtask

  task automatic test_reset_mid_attack();
    clear_keys(); do_reset();
    p1_atk = 1'b1; p2_def = 1'b1;
    for (int t = 1; t <= 4; t++) tick();
    n_checks++;
    if (p1_state !== 3'(S_ACTIVE)) begin
      n_fail++; $display("FAIL midrst_pre got=%0d exp=3", p1_state);
    end
    Reset = 1'b1; frame_tick = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0; frame_tick = 1'b0;
    n_checks++;
    if ({p1_state, p1_dir, p1_strike, p1_blocking, p2_state, p2_dir, p2_strike, p2_blocking} !== 14'h0) begin
      n_fail++;
      $display("FAIL midrst_zero got=%h exp=0", {p1_state, p1_dir, p1_strike, p1_blocking, p2_state, p2_dir, p2_strike, p2_blocking});
    end
    tick();
    n_checks++;
    if (p1_state !== 3'(S_WINDUP) || p2_state !== 3'(S_BLOCK)) begin
      n_fail++; $display("FAIL midrst_repress got=%0d/%0d exp=2/5", p1_state, p2_state);
    end
  endtask

  task automatic test_tick_gating();
    clear_keys(); do_reset();
    p1_r = 1'b1; p2_def = 1'b1;
    tick();
    for (int i = 0; i < 50; i++) begin
      rand_keys();
      gap();
      n_checks++;
      if ({p1_state, p1_dir, p2_state, p2_blocking, p1_strike, p2_strike} !== {3'd1, 2'b10, 3'd5, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL gating cyc=%0d got=%b exp=%b", i, {p1_state, p1_dir, p2_state, p2_blocking, p1_strike, p2_strike},
                 {3'd1, 2'b10, 3'd5, 1'b1, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_buffer();
    int strikes = 0;
    int exp_st10, exp_st16, exp_strikes;
`ifdef ATTACK_BUFFER_EN
    exp_st10 = S_WINDUP; exp_st16 = S_RECOVER; exp_strikes = 1;
`else
    exp_st10 = S_IDLE; exp_st16 = S_IDLE; exp_strikes = 0;
`endif
    clear_keys(); do_reset();
    p1_atk = 1'b1; tick();
    p1_atk = 1'b0;
    for (int t = 2; t <= 6; t++) tick();
    p1_atk = 1'b1; tick();
    n_checks++;
    if (p1_state !== 3'(S_RECOVER)) begin
      n_fail++; $display("FAIL buf_recover got=%0d exp=4", p1_state);
    end
    tick(); tick(); tick();
    n_checks++;
    if (p1_state !== 3'(exp_st10)) begin
      n_fail++; $display("FAIL buf_expire got=%0d exp=%0d", p1_state, exp_st10);
    end
    for (int t = 11; t <= 16; t++) begin
      tick();
      strikes += int'(p1_strike);
    end
    n_checks++;
    if (strikes != exp_strikes || p1_state !== 3'(exp_st16)) begin
      n_fail++; $display("FAIL buf_second got_strikes=%0d state=%0d exp=%0d/%0d", strikes, p1_state, exp_strikes, exp_st16);
    end
  endtask

  task automatic test_random();
    logic [2:0] ds;
    logic [1:0] dd;
    logic dk, db;
    clear_keys(); do_reset();
    for (int i = 0; i < 600; i++) begin
      rand_keys();
      if ($urandom_range(1) == 1) p2_def = p2_atk;
      if ($urandom_range(59) == 0) begin
        Reset = 1'b1; frame_tick = 1'($urandom_range(1));
        @(posedge Clk); #1;
        Reset = 1'b0; frame_tick = 1'b0;
        model_reset();
      end else begin
        model_tick(0, p1_l, p1_r, p1_atk, p1_def);
        model_tick(1, p2_l, p2_r, p2_atk, p2_def);
        tick();
      end
      for (int p = 0; p < 2; p++) begin
        ds = p ? p2_state : p1_state;
        dd = p ? p2_dir : p1_dir;
        dk = p ? p2_strike : p1_strike;
        db = p ? p2_blocking : p1_blocking;
        n_checks++;
        if (ds !== 3'(m_phase[p]) || dd !== 2'(m_dir[p]) || dk !== m_strike[p] || db !== (m_phase[p] == S_BLOCK)) begin
          n_fail++;
          $display("FAIL random it=%0d p%0d got st=%0d dir=%0d stk=%b blk=%b exp st=%0d dir=%0d stk=%b blk=%b",
                   i, p + 1, ds, dd, dk, db, m_phase[p], m_dir[p], m_strike[p], (m_phase[p] == S_BLOCK));
        end
      end
      if ($urandom_range(1) == 1) begin
        rand_keys();
        gap();
        m_strike[0] = 0; m_strike[1] = 0;
        n_checks++;
        if (p1_strike !== 1'b0 || p2_strike !== 1'b0 || p1_state !== 3'(m_phase[0]) || p2_state !== 3'(m_phase[1])) begin
          n_fail++;
          $display("FAIL random_gap it=%0d got stk=%b%b st=%0d/%0d exp stk=00 st=%0d/%0d",
                   i, p1_strike, p2_strike, p1_state, p2_state, m_phase[0], m_phase[1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_attack_hold();
    test_p2_atk_def();
    test_walk();
    test_reset_mid_attack();
    test_tick_gating();
    test_buffer();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
